// File: rtl/gate_sweep_pkg.sv
// Shared constants for the gate sweep sequencer: FSM state encodings,
// truth tables for the common 2-input cells, and a counter-width helper.
package gate_sweep_pkg;

  // FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Expected gate output indexed by {in1,in2}
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int ceil_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// Settle-window down-counter. A load pulse arms it with SETTLE_CYC-1 so that
// the zero flag is seen after exactly SETTLE_CYC enabled cycles.
module gate_sweep_timer
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int            W        = ceil_w(SETTLE_CYC);
  localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE_CYC - 1);

  logic [W-1:0] cnt;

  // Load wins over counting; the count parks at zero once reached.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= LOAD_VAL;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a single 2-input gate cell. Drives the four
// input vectors, waits a settle window, compares the gate output against a
// latched truth table and counts mismatches.
// Optional macro GATE_SWEEP_ERRLOG_EN adds fail_vld/fail_vec/fail_val, which
// capture the first mismatching vector of a sweep and its sampled output.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       truth_tbl,
  input  logic             dut_out,
  output logic             dut_in1,
  output logic             dut_in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_SWEEP_ERRLOG_EN
  ,
  output logic             fail_vld,
  output logic [1:0]       fail_vec,
  output logic             fail_val
`endif
);

  localparam int               PW        = ceil_w(NUM_PASSES);
  localparam logic [PW-1:0]    LAST_PASS = PW'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [2:0]    state;
  logic [3:0]    tt_q;
  logic [1:0]    vec;
  logic [PW-1:0] pass_idx;
  logic          timer_zero;
  logic          mismatch;

  // NOTE: case inequality so an X or Z on the gate output is a mismatch
  // rather than an unknown compare that would silently be skipped.
  assign mismatch = (dut_out !== tt_q[vec]);

  gate_sweep_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_DRIVE),
    .en   (state == ST_SETTLE),
    .zero (timer_zero)
  );

  // Sweep FSM with vector/pass counters, compare and saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tt_q     <= '0;
      vec      <= '0;
      pass_idx <= '0;
      dut_in1  <= 1'b0;
      dut_in2  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tt_q     <= truth_tbl;
            err_cnt  <= '0;
            pass     <= 1'b0;
            vec      <= '0;
            pass_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          dut_in1 <= vec[1];
          dut_in2 <= vec[0];
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= ST_DRIVE;
          end else if (pass_idx != LAST_PASS) begin
            vec      <= '0;
            pass_idx <= pass_idx + 1'b1;
            state    <= ST_DRIVE;
          end else begin
            // Verdict folds in this final sample, so done and pass align.
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          dut_in1 <= 1'b0;
          dut_in2 <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_SWEEP_ERRLOG_EN
  // First-mismatch capture; later mismatches in the same sweep are ignored.
  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && start)) begin
      fail_vld <= 1'b0;
      fail_vec <= '0;
      fail_val <= 1'b0;
    end else if (state == ST_SAMPLE && mismatch && !fail_vld) begin
      fail_vld <= 1'b1;
      fail_vec <= vec;
      fail_val <= dut_out;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl. Three instances: default parameters
// with an OR gate, NUM_PASSES=2 with an OR gate, and NUM_PASSES=8 driving a
// stuck-at-0 output. Cycle n means the interval after the n-th rising edge
// counted from the edge that accepts start (that edge is cycle 0's end).
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic clk, rst;
  int   n_tests, n_fail;

  // instance 0: defaults, OR gate
  logic       start0, in1_0, in2_0, busy0, done0, pass0, out0;
  logic [3:0] tt0, err0;
  // instance 2: two passes, OR gate
  logic       start2, in1_2, in2_2, busy2, done2, pass2, out2;
  logic [3:0] tt2, err2;
  // instance 8: eight passes, stuck-at-0 output
  logic       start8, in1_8, in2_8, busy8, done8, pass8, out8;
  logic [3:0] tt8, err8;
`ifdef GATE_SWEEP_ERRLOG_EN
  logic       fvld0, fval0, fvld2, fval2, fvld8, fval8;
  logic [1:0] fvec0, fvec2, fvec8;
`endif

  assign out0 = in1_0 | in2_0;
  assign out2 = in1_2 | in2_2;
  assign out8 = 1'b0;

  gate_sweep_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .truth_tbl(tt0), .dut_out(out0),
    .dut_in1(in1_0), .dut_in2(in2_0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .fail_vld(fvld0), .fail_vec(fvec0), .fail_val(fval0)
`endif
  );

  gate_sweep_ctrl #(.SETTLE_CYC(2), .NUM_PASSES(2), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .truth_tbl(tt2), .dut_out(out2),
    .dut_in1(in1_2), .dut_in2(in2_2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .fail_vld(fvld2), .fail_vec(fvec2), .fail_val(fval2)
`endif
  );

  gate_sweep_ctrl #(.SETTLE_CYC(2), .NUM_PASSES(8), .ERR_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .truth_tbl(tt8), .dut_out(out8),
    .dut_in1(in1_8), .dut_in2(in2_8), .busy(busy8), .done(done8),
    .pass(pass8), .err_cnt(err8)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .fail_vld(fvld8), .fail_vec(fvec8), .fail_val(fval8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sweep on instance 0. Start is held for the accept edge only, an
  // optional extra start pulse is sampled at the end of cycle pulse_at, and
  // truth_tbl is scrambled right after acceptance. Records done timing,
  // busy profile errors and driven-vector errors over 24 cycles.
  task automatic run0(input logic [3:0] tt, input int pulse_at,
                      output int done_at, output int n_done,
                      output int busy_bad, output int vec_bad);
    done_at = 0; n_done = 0; busy_bad = 0; vec_bad = 0;
    @(negedge clk);
    tt0    = tt;
    start0 = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = (cyc == pulse_at);
      if (cyc == 1) tt0 = TT_NOR;
      if (done0) begin
        n_done++;
        if (done_at == 0) done_at = cyc;
      end
      if (busy0 !== (cyc <= 17)) busy_bad++;
      // vector v is on the gate pins from cycle 4v+2 to 4v+5
      if (cyc <= 15 && cyc % 4 == 3 && {in1_0, in2_0} !== 2'(cyc / 4)) vec_bad++;
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 0; start2 = 0; start8 = 0;
    tt0 = '0; tt2 = '0; tt8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy0, done0, pass0, err0, in1_0, in2_0} !== 9'd0) begin
      n_fail++; $display("FAIL reset_inst0: got %b expected 0", {busy0, done0, pass0, err0, in1_0, in2_0});
    end
    n_tests++;
    if ({busy2, done2, pass2, err2, in1_2, in2_2} !== 9'd0) begin
      n_fail++; $display("FAIL reset_inst2: got %b expected 0", {busy2, done2, pass2, err2, in1_2, in2_2});
    end
    n_tests++;
    if ({busy8, done8, pass8, err8, in1_8, in2_8} !== 9'd0) begin
      n_fail++; $display("FAIL reset_inst8: got %b expected 0", {busy8, done8, pass8, err8, in1_8, in2_8});
    end
`ifdef GATE_SWEEP_ERRLOG_EN
    n_tests++;
    if ({fvld0, fvec0, fval0} !== 4'd0) begin
      n_fail++; $display("FAIL reset_errlog: got %b expected 0", {fvld0, fvec0, fval0});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_or_sweep();
    int d_at, n_d, b_bad, v_bad;
    run0(TT_OR, 0, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if (d_at != 17) begin n_fail++; $display("FAIL or_done_cycle: got %0d expected 17", d_at); end
    n_tests++;
    if (n_d != 1) begin n_fail++; $display("FAIL or_done_pulses: got %0d expected 1", n_d); end
    n_tests++;
    if (b_bad != 0) begin n_fail++; $display("FAIL or_busy_profile: got %0d bad cycles expected 0", b_bad); end
    n_tests++;
    if (v_bad != 0) begin n_fail++; $display("FAIL or_vectors: got %0d bad cycles expected 0", v_bad); end
    n_tests++;
    if (err0 !== 4'd0) begin n_fail++; $display("FAIL or_err_cnt: got %0d expected 0", err0); end
    n_tests++;
    if (pass0 !== 1'b1) begin n_fail++; $display("FAIL or_pass: got %b expected 1", pass0); end
    n_tests++;
    if ({in1_0, in2_0} !== 2'b00) begin n_fail++; $display("FAIL or_idle_inputs: got %b expected 00", {in1_0, in2_0}); end
  endtask

  task automatic test_start_ignored();
    int d_at, n_d, b_bad, v_bad;
    run0(TT_OR, 5, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if (d_at != 17 || n_d != 1) begin
      n_fail++; $display("FAIL busy_start: got done at %0d x%0d expected 17 x1", d_at, n_d);
    end
    // start sampled at the end of the DONE cycle: no restart, busy drops
    run0(TT_AND, 17, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if (d_at != 17 || n_d != 1 || b_bad != 0) begin
      n_fail++; $display("FAIL done_start: got done at %0d x%0d busy_bad %0d expected 17 x1 0", d_at, n_d, b_bad);
    end
    n_tests++;
    if (err0 !== 4'd2) begin n_fail++; $display("FAIL and_err_cnt: got %0d expected 2", err0); end
    n_tests++;
    if (pass0 !== 1'b0) begin n_fail++; $display("FAIL and_pass: got %b expected 0", pass0); end
  endtask

  task automatic test_start_held();
    int first, second, n_d;
    first = 0; second = 0; n_d = 0;
    @(negedge clk);
    tt0 = TT_OR;
    start0 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 35) start0 = 1'b0;
      if (done0) begin
        n_d++;
        if (first == 0) first = cyc;
        else if (second == 0) second = cyc;
      end
    end
    start0 = 1'b0;
    n_tests++;
    if (first != 17 || second != 35 || n_d != 2) begin
      n_fail++; $display("FAIL held_start: got done at %0d,%0d x%0d expected 17,35 x2", first, second, n_d);
    end
    n_tests++;
    if (busy0 !== 1'b0 || pass0 !== 1'b1) begin
      n_fail++; $display("FAIL held_final: got busy %b pass %b expected 0 1", busy0, pass0);
    end
  endtask

  task automatic test_rst_mid();
    int d_at, n_d, b_bad, v_bad;
    @(negedge clk);
    tt0 = TT_NOR;
    start0 = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
    end
    // vector 00 already mismatched against NOR, so there is state to discard
    n_tests++;
    if (err0 !== 4'd1 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_state: got err %0d busy %b expected 1 1", err0, busy0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy0, done0, pass0, err0, in1_0, in2_0} !== 9'd0) begin
      n_fail++; $display("FAIL mid_rst: got %b expected 0", {busy0, done0, pass0, err0, in1_0, in2_0});
    end
    rst = 1'b0;
    run0(TT_OR, 0, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if (d_at != 17 || n_d != 1 || err0 !== 4'd0 || pass0 !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_sweep: got done %0d x%0d err %0d pass %b expected 17 x1 0 1", d_at, n_d, err0, pass0);
    end
  endtask

  task automatic test_multi_pass();
    int d_at, n_d;
    d_at = 0; n_d = 0;
    @(negedge clk);
    tt2 = TT_AND;
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin n_d++; if (d_at == 0) d_at = cyc; end
    end
    n_tests++;
    if (d_at != 33 || n_d != 1) begin n_fail++; $display("FAIL pass2_done: got %0d x%0d expected 33 x1", d_at, n_d); end
    n_tests++;
    if (err2 !== 4'd4) begin n_fail++; $display("FAIL pass2_err_cnt: got %0d expected 4", err2); end
    n_tests++;
    if (pass2 !== 1'b0) begin n_fail++; $display("FAIL pass2_pass: got %b expected 0", pass2); end
  endtask

  task automatic test_saturate();
    int d_at, n_d;
    d_at = 0; n_d = 0;
    @(negedge clk);
    tt8 = TT_OR;
    start8 = 1'b1;
    for (int cyc = 1; cyc <= 160; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin n_d++; if (d_at == 0) d_at = cyc; end
    end
    n_tests++;
    if (d_at != 129 || n_d != 1) begin n_fail++; $display("FAIL sat_done: got %0d x%0d expected 129 x1", d_at, n_d); end
    n_tests++;
    if (err8 !== 4'd15) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected 15", err8); end
    n_tests++;
    if (pass8 !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b expected 0", pass8); end
  endtask

`ifdef GATE_SWEEP_ERRLOG_EN
  task automatic test_errlog();
    int d_at, n_d, b_bad, v_bad;
    run0(TT_NOR, 0, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if ({fvld0, fvec0, fval0} !== 4'b1000) begin
      n_fail++; $display("FAIL errlog_capture: got vld %b vec %b val %b expected 1 00 0", fvld0, fvec0, fval0);
    end
    n_tests++;
    if (err0 !== 4'd4) begin n_fail++; $display("FAIL nor_err_cnt: got %0d expected 4", err0); end
    run0(TT_OR, 0, d_at, n_d, b_bad, v_bad);
    n_tests++;
    if ({fvld0, fvec0, fval0} !== 4'b0000) begin
      n_fail++; $display("FAIL errlog_clear: got vld %b vec %b val %b expected 0 00 0", fvld0, fvec0, fval0);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    test_reset();
    test_or_sweep();
    test_start_ignored();
    test_start_held();
    test_rst_mid();
    test_multi_pass();
    test_saturate();
`ifdef GATE_SWEEP_ERRLOG_EN
    test_errlog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
